// File: rtl/cpu_pkg.sv
// Shared processor definitions: ALU control-vector bit positions, opcode field
// location, load/store opcodes and the EX/MEM pipeline register layout.
package cpu_pkg;

   localparam int XLEN     = 16;
   localparam int NUM_OPS  = 12;
   localparam int IMM_W    = 5;
   localparam int SHAMT_W  = 4;

   // One-hot bit positions inside alusignals
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_CMP  = 2;
   localparam int ALU_MOV  = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_OR   = 5;
   localparam int ALU_MUL  = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_ASR  = 8;
   localparam int ALU_NOT  = 9;
   localparam int ALU_LSL  = 10;
   localparam int ALU_LSR  = 11;

   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 12;
   localparam int OPC_W    = OPC_HI - OPC_LO + 1;

   localparam logic [OPC_W-1:0] LD_OPCODE_DEF = 4'hA;
   localparam logic [OPC_W-1:0] ST_OPCODE_DEF = 4'hB;

   typedef struct packed {
      logic [XLEN-1:0] aluresult;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] op2;
      logic            iswb;
      logic            isld;
      logic            isst;
   } ex_mem_t;

   function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit ALU; the lowest set bit of the one-hot select wins,
// and an all-zero select yields zero.
module alu_core
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0]    a,
   input  logic [XLEN-1:0]    b,
   input  logic [NUM_OPS-1:0] sel,
   output logic [XLEN-1:0]    result
);

   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    add_r;
   logic [XLEN-1:0]    sub_r;
   logic [XLEN-1:0]    cmp_r;
   logic [XLEN-1:0]    mul_r;
   logic [XLEN-1:0]    asr_r;
   logic [XLEN-1:0]    lsl_r;
   logic [XLEN-1:0]    lsr_r;
   logic               gt_s;
   logic               eq;

   assign shamt = b[SHAMT_W-1:0];
   assign add_r = a + b;
   assign sub_r = a - b;
   assign mul_r = a * b;
   assign gt_s  = $signed(a) > $signed(b);
   assign eq    = (a == b);
   assign cmp_r = {{(XLEN-2){1'b0}}, gt_s, eq};
   assign asr_r = $signed(a) >>> shamt;
   assign lsl_r = a << shamt;
   assign lsr_r = a >> shamt;

   // Chain order encodes the priority: lower bit index is tested first
   always_comb begin
      result = '0;
      if      (sel[ALU_ADD]) result = add_r;
      else if (sel[ALU_SUB]) result = sub_r;
      else if (sel[ALU_CMP]) result = cmp_r;
      else if (sel[ALU_MOV]) result = b;
      else if (sel[ALU_AND]) result = a & b;
      else if (sel[ALU_OR])  result = a | b;
      else if (sel[ALU_MUL]) result = mul_r;
      else if (sel[ALU_XOR]) result = a ^ b;
      else if (sel[ALU_ASR]) result = asr_r;
      else if (sel[ALU_NOT]) result = ~a;
      else if (sel[ALU_LSL]) result = lsl_r;
      else if (sel[ALU_LSR]) result = lsr_r;
   end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: operand-B select, ALU, load/store decode and the EX/MEM register.
// There is no handshake: the stage captures a new instruction on every rising edge.
module alu_stage
   import cpu_pkg::*;
#(
   parameter logic [3:0] LD_OPCODE = LD_OPCODE_DEF,
   parameter logic [3:0] ST_OPCODE = ST_OPCODE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_OPS-1:0]  alusignals,
   input  logic [XLEN-1:0]     instrin,
   input  logic [XLEN-1:0]     op1,
   input  logic [XLEN-1:0]     op2,
   input  logic [IMM_W-1:0]    immx,
   input  logic                iswb,
   input  logic                isimmediate,
   input  logic                is_branch_takenin,
   output logic [XLEN-1:0]     aluresult,
   output logic [XLEN-1:0]     instrout,
   output logic                isld1,
   output logic                isst1,
   output logic [XLEN-1:0]     op2_out,
   output logic                iswb_out
);

   logic [XLEN-1:0]  op_b;
   logic [XLEN-1:0]  alu_res;
   logic [OPC_W-1:0] opcode;
   ex_mem_t          ex_mem_d;
   ex_mem_t          ex_mem_q;

   assign op_b   = isimmediate ? sext_imm(immx) : op2;
   assign opcode = instrin[OPC_HI:OPC_LO];

   alu_core u_alu_core (
      .a      (op1),
      .b      (op_b),
      .sel    (alusignals),
      .result (alu_res)
   );

   // Store data is always the register value, even when B comes from the immediate
   always_comb begin
      ex_mem_d           = '0;
      ex_mem_d.aluresult = alu_res;
      ex_mem_d.instr     = instrin;
      ex_mem_d.op2       = op2;
      ex_mem_d.iswb      = iswb;
      ex_mem_d.isld      = (opcode == LD_OPCODE);
      ex_mem_d.isst      = (opcode == ST_OPCODE);
   end

   // A taken branch inserts an all-zero bubble; instr=0 is a NOP downstream
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_mem_q <= '0;
      end else if (is_branch_takenin) begin
         ex_mem_q <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
      end
   end

   assign aluresult = ex_mem_q.aluresult;
   assign instrout  = ex_mem_q.instr;
   assign isld1     = ex_mem_q.isld;
   assign isst1     = ex_mem_q.isst;
   assign op2_out   = ex_mem_q.op2;
   assign iswb_out  = ex_mem_q.iswb;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: each step drives one instruction, takes one
// edge and compares every output against hand-computed values.
module tb_alu_stage;

   logic        clk;
   logic        reset;
   logic [11:0] alusignals;
   logic [15:0] instrin;
   logic [15:0] op1;
   logic [15:0] op2;
   logic [4:0]  immx;
   logic        iswb;
   logic        isimmediate;
   logic        is_branch_takenin;
   logic [15:0] aluresult;
   logic [15:0] instrout;
   logic        isld1;
   logic        isst1;
   logic [15:0] op2_out;
   logic        iswb_out;

   int checks = 0;
   int errors = 0;

   alu_stage dut (
      .clk               (clk),
      .reset             (reset),
      .alusignals        (alusignals),
      .instrin           (instrin),
      .op1               (op1),
      .op2               (op2),
      .immx              (immx),
      .iswb              (iswb),
      .isimmediate       (isimmediate),
      .is_branch_takenin (is_branch_takenin),
      .aluresult         (aluresult),
      .instrout          (instrout),
      .isld1             (isld1),
      .isst1             (isst1),
      .op2_out           (op2_out),
      .iswb_out          (iswb_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] res, input logic [15:0] ins,
                          input logic ld, input logic st, input logic [15:0] o2, input logic wb);
      chk({tag, ".aluresult"}, aluresult, res);
      chk({tag, ".instrout"},  instrout,  ins);
      chk({tag, ".isld1"},     {15'b0, isld1},    {15'b0, ld});
      chk({tag, ".isst1"},     {15'b0, isst1},    {15'b0, st});
      chk({tag, ".op2_out"},   op2_out,   o2);
      chk({tag, ".iswb_out"},  {15'b0, iswb_out}, {15'b0, wb});
   endtask

   // Drive one instruction, then sample 1 time unit after the capturing edge
   task automatic step(input logic [11:0] sel, input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] imm, input logic isimm,
                       input logic wb, input logic br);
      alusignals        = sel;
      instrin           = ins;
      op1               = a;
      op2               = b;
      immx              = imm;
      isimmediate       = isimm;
      iswb              = wb;
      is_branch_takenin = br;
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input string tag, input int bit_idx, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
      logic [11:0] sel;
      sel = 12'b0;
      sel[bit_idx] = 1'b1;
      step(sel, 16'h1000, a, b, 5'd0, 1'b0, 1'b1, 1'b0);
      chk(tag, aluresult, exp);
   endtask

   initial begin
      reset = 1'b1;
      step(12'h001, 16'hA5A5, 16'h1111, 16'h2222, 5'h1F, 1'b0, 1'b1, 1'b0);
      chk_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      reset = 1'b0;

      step(12'h001, 16'h1000, 16'd10, 16'd20, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_all("add_reg", 16'd30, 16'h1000, 1'b0, 1'b0, 16'd20, 1'b1);

      alu_op("sub",      1,  16'd8,    16'd7,    16'd1);
      alu_op("cmp_lt",   2,  16'd10,   16'd20,   16'h0000);
      alu_op("cmp_gt",   2,  16'd20,   16'd10,   16'h0002);
      alu_op("cmp_eq",   2,  16'd5,    16'd5,    16'h0001);
      alu_op("cmp_sgn",  2,  16'hFFFF, 16'h0001, 16'h0000);
      alu_op("cmp_sgn2", 2,  16'h0001, 16'h8000, 16'h0002);
      alu_op("mov",      3,  16'd10,   16'd20,   16'd20);
      alu_op("and",      4,  16'h00AA, 16'h00F0, 16'h00A0);
      alu_op("or",       5,  16'h00AA, 16'h0055, 16'h00FF);
      alu_op("mul",      6,  16'd5,    16'd3,    16'd15);
      alu_op("mul_wrap", 6,  16'h1234, 16'h0010, 16'h2340);
      alu_op("xor",      7,  16'h00AA, 16'h00FF, 16'h0055);
      alu_op("asr",      8,  16'h8000, 16'd4,    16'hF800);
      alu_op("asr_pos",  8,  16'h4000, 16'd4,    16'h0400);
      alu_op("not",      9,  16'hF0F0, 16'd0,    16'h0F0F);
      alu_op("lsl",      10, 16'h000F, 16'd4,    16'h00F0);
      alu_op("lsr",      11, 16'hF000, 16'd4,    16'h0F00);
      alu_op("lsl_sh20", 10, 16'h000F, 16'd20,   16'h00F0);
      alu_op("lsr_sh20", 11, 16'hF000, 16'd20,   16'h0F00);
      alu_op("add_wrap", 0,  16'hFFFF, 16'h0002, 16'h0001);
      alu_op("sub_wrap", 1,  16'h0000, 16'h0001, 16'hFFFF);

      step(12'h001, 16'h2000, 16'd10, 16'h7777, 5'd5, 1'b1, 1'b1, 1'b0);
      chk_all("add_imm5", 16'd15, 16'h2000, 1'b0, 1'b0, 16'h7777, 1'b1);
      step(12'h001, 16'h2001, 16'd10, 16'h7777, 5'b11111, 1'b1, 1'b1, 1'b0);
      chk("add_imm_m1", aluresult, 16'd9);
      step(12'h008, 16'h2002, 16'd10, 16'h7777, 5'b10000, 1'b1, 1'b1, 1'b0);
      chk("mov_imm_m16", aluresult, 16'hFFF0);

      step(12'h001, 16'hA123, 16'h0100, 16'h1234, 5'd4, 1'b1, 1'b1, 1'b0);
      chk_all("load", 16'h0104, 16'hA123, 1'b1, 1'b0, 16'h1234, 1'b1);
      step(12'h001, 16'hB456, 16'h0200, 16'h5678, 5'h1E, 1'b1, 1'b0, 1'b0);
      chk_all("store", 16'h01FE, 16'hB456, 1'b0, 1'b1, 16'h5678, 1'b0);

      step(12'h001, 16'h1111, 16'd10, 16'd20, 5'd0, 1'b0, 1'b1, 1'b1);
      chk_all("flush", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      step(12'h001, 16'h1222, 16'd1, 16'd2, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_all("post_flush", 16'd3, 16'h1222, 1'b0, 1'b0, 16'd2, 1'b1);

      step(12'hA01, 16'hA333, 16'd10, 16'd20, 5'd0, 1'b0, 1'b1, 1'b1);
      chk_all("flush_ld", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

      reset = 1'b1;
      step(12'h001, 16'hB444, 16'd10, 16'd20, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_all("reset_mid", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      reset = 1'b0;
      step(12'h001, 16'hB555, 16'd7, 16'd8, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_all("post_reset", 16'd15, 16'hB555, 1'b0, 1'b1, 16'd8, 1'b0);

      step(12'b0000_0000_0011, 16'h1000, 16'd10, 16'd20, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("prio_add_sub", aluresult, 16'd30);
      step(12'b1100_0000_0000, 16'h1000, 16'h000F, 16'd4, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("prio_lsl_lsr", aluresult, 16'h00F0);
      step(12'b0000_1000_0100, 16'h1000, 16'd20, 16'd10, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("prio_cmp_xor", aluresult, 16'h0002);
      step(12'h000, 16'h1000, 16'd10, 16'd20, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("sel_zero", aluresult, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
